cache_arbiter: RTL and testbench

Two-port to one-port line arbiter between the L1 instruction cache (port I, read-only) and the L1 data cache (port D, read/write), driving the single 256-bit physical-memory interface. It sits inside the cache group, directly downstream of both L1 miss/writeback controllers and directly upstream of `pmem_*`. It serializes line transfers, applies round-robin fairness on simultaneous requests, and routes each response back to the requester.

---
 rtl/cache_arbiter.sv | 127 ++++++++++++
 tb/tb_cache_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// Two-port to one-port line arbiter: L1 I-cache (read-only) and L1 D-cache (read/write)
// share a single physical-memory port. Round-robin on ties, one transaction in flight.
module cache_arbiter #(
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  imem_read,
  input  logic [ADDR_WIDTH-1:0] imem_address,
  output logic [LINE_WIDTH-1:0] imem_rdata,
  output logic                  imem_resp,

  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic [ADDR_WIDTH-1:0] dmem_address,
  input  logic [LINE_WIDTH-1:0] dmem_wdata,
  output logic [LINE_WIDTH-1:0] dmem_rdata,
  output logic                  dmem_resp,

  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {StIdle, StServeI, StServeD} state_e;

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;  // 0 = I served last, 1 = D
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

  logic i_req, d_req;

  assign i_req = imem_read;
  assign d_req = dmem_read | dmem_write;

  // pmem outputs come straight from registers, so requests never reach them combinationally.
  assign pmem_read    = read_q;
  assign pmem_write   = write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  // Read data is broadcast to both ports; only *_resp qualifies it.
  assign imem_rdata = pmem_rdata;
  assign dmem_rdata = pmem_rdata;

  // Arbitration, request latching and completion handling.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    read_d       = read_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    imem_resp    = 1'b0;
    dmem_resp    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // I wins when alone, or on a tie when D was served last.
        if (i_req && (!d_req || last_grant_q)) begin
          state_d = StServeI;
          addr_d  = imem_address;
          read_d  = 1'b1;
          write_d = 1'b0;
        end else if (d_req) begin
          state_d = StServeD;
          addr_d  = dmem_address;
          wdata_d = dmem_wdata;
          // Read and write together is illegal; treat it as a writeback.
          write_d = dmem_write;
          read_d  = ~dmem_write;
        end
      end
      StServeI: begin
        if (pmem_resp) begin
          imem_resp    = 1'b1;
          last_grant_d = 1'b0;
          read_d       = 1'b0;
          write_d      = 1'b0;
          state_d      = StIdle;
        end
      end
      StServeD: begin
        if (pmem_resp) begin
          dmem_resp    = 1'b1;
          last_grant_d = 1'b1;
          read_d       = 1'b0;
          write_d      = 1'b0;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        read_d  = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  // State and latched transaction registers; reset abandons any pending transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      read_q       <= read_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: transaction table plus reset and spurious-response sequences.
module tb_cache_arbiter;

  localparam int unsigned LW = 256;
  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst;
  logic          imem_read;
  logic [AW-1:0] imem_address;
  logic [LW-1:0] imem_rdata;
  logic          imem_resp;
  logic          dmem_read;
  logic          dmem_write;
  logic [AW-1:0] dmem_address;
  logic [LW-1:0] dmem_wdata;
  logic [LW-1:0] dmem_rdata;
  logic          dmem_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  cache_arbiter #(
    .LINE_WIDTH(LW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_address (dmem_address),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic          i_rd;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] i_addr;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            delay;     // idle cycles before pmem_resp
    logic          exp_d;     // 1 = D expected to be granted
    logic          exp_wr;    // 1 = expected pmem_write, else pmem_read
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs [9];

  localparam logic [LW-1:0] A5 = {32{8'hA5}};
  localparam logic [LW-1:0] DB = {8{32'hDEADBEEF}};

  // Runs one transaction starting in an IDLE cycle (called at a negedge).
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    imem_read    = v.i_rd;
    dmem_read    = v.d_rd;
    dmem_write   = v.d_wr;
    imem_address = v.i_addr;
    dmem_address = v.d_addr;
    dmem_wdata   = v.wdata;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " pmem_read"},    pmem_read,    !v.exp_wr);
    chk({tag, " pmem_write"},   pmem_write,   v.exp_wr);
    chk({tag, " pmem_address"}, pmem_address, v.exp_addr);
    if (v.exp_wr) chk({tag, " pmem_wdata"}, pmem_wdata, v.wdata);
    repeat (v.delay) @(negedge clk);
    chk({tag, " strobe held"}, pmem_read | pmem_write, 1'b1);
    chk({tag, " no early resp"}, {imem_resp, dmem_resp}, 2'b00);
    pmem_rdata = v.rdata;
    pmem_resp  = 1'b1;
    #1;
    chk({tag, " imem_resp"}, imem_resp, !v.exp_d);
    chk({tag, " dmem_resp"}, dmem_resp, v.exp_d);
    chk({tag, " rdata"}, v.exp_d ? dmem_rdata : imem_rdata, v.rdata);
    @(posedge clk);
    @(negedge clk);
    pmem_resp = 1'b0;
    chk({tag, " strobes drop"}, {pmem_read, pmem_write}, 2'b00);
    chk({tag, " resp drop"}, {imem_resp, dmem_resp}, 2'b00);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h60,   32'h1000, DB,         A5,          3, 1'b0, 1'b0, 32'h60};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h60,   32'h1000, DB,         {64{4'h1}},  1, 1'b1, 1'b1, 32'h1000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h200,  32'h300,  {64{4'h2}}, {64{4'h3}},  0, 1'b0, 1'b0, 32'h200};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 32'h200,  32'h300,  {64{4'h2}}, {64{4'h4}},  2, 1'b1, 1'b0, 32'h300};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h200,  32'h300,  {64{4'h2}}, {64{4'h5}},  0, 1'b0, 1'b0, 32'h200};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h400,  32'h2000, {64{4'h6}}, {64{4'h7}},  1, 1'b1, 1'b1, 32'h2000};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h400,  32'h3000, {64{4'h6}}, {64{4'h8}},  0, 1'b0, 1'b0, 32'h400};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h400,  32'h3000, {64{4'h6}}, {64{4'h9}},  0, 1'b1, 1'b0, 32'h3000};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 32'h400,  32'h4000, {64{4'hC}}, {64{4'hD}},  1, 1'b1, 1'b1, 32'h4000};

    rst          = 1'b1;
    imem_read    = 1'b0;
    imem_address = '0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_address = '0;
    dmem_wdata   = '0;
    pmem_rdata   = {64{4'h3}};
    pmem_resp    = 1'b0;

    // Reset values and rdata pass-through during reset.
    #12;
    chk("rst pmem_read",    pmem_read,    1'b0);
    chk("rst pmem_write",   pmem_write,   1'b0);
    chk("rst pmem_address", pmem_address, '0);
    chk("rst pmem_wdata",   pmem_wdata,   '0);
    chk("rst resp",         {imem_resp, dmem_resp}, 2'b00);
    chk("rst imem_rdata",   imem_rdata,   {64{4'h3}});
    chk("rst dmem_rdata",   dmem_rdata,   {64{4'h3}});
    @(negedge clk);
    rst = 1'b0;

    // Spurious pmem_resp in IDLE is ignored.
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    chk("spur resp", {imem_resp, dmem_resp}, 2'b00);
    @(posedge clk);
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("spur strobes", {pmem_read, pmem_write}, 2'b00);
    chk("spur address", pmem_address, '0);

    // Reset in the middle of a D writeback.
    dmem_write   = 1'b1;
    dmem_address = 32'h1000;
    dmem_wdata   = DB;
    @(posedge clk);
    @(negedge clk);
    chk("mid pmem_write", pmem_write, 1'b1);
    chk("mid pmem_wdata", pmem_wdata, DB);
    #2;
    rst       = 1'b1;
    pmem_resp = 1'b1;
    #1;
    chk("abort pmem_write",   pmem_write,   1'b0);
    chk("abort pmem_address", pmem_address, '0);
    chk("abort pmem_wdata",   pmem_wdata,   '0);
    chk("abort dmem_resp",    dmem_resp,    1'b0);
    dmem_write = 1'b0;
    pmem_resp  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Table: simultaneous start from reset, alternation, no starvation, illegal rd+wr.
    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    imem_read  = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
